sdram_port_arbiter: RTL and testbench

- Shares the single SDRAM controller native command port between two requesters: master 0 (CPU bus bridge) and master 1 (SD-card DMA engine).
- Serialises commands, arbitrates by round-robin or by CPU priority with a starvation guard, and tracks outstanding reads so returned data is steered to the correct master.
- Sits inside super6502_fpga on the i_sysclk domain, between the bus bridges and the SDRAM controller user port.

---
 rtl/sdram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-master front end for the SDRAM controller native command port.
// Serialises commands and steers in-order read returns back to their issuer.
module sdram_port_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_RD       = 4,
   parameter int PRIO_MODE    = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                    i_sysclk,
   input  logic                    i_rst_n,
   input  logic                    i_m0_req,
   input  logic                    i_m0_we,
   input  logic [ADDR_WIDTH-1:0]   i_m0_addr,
   input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_m0_wmask,
   output logic                    o_m0_ack,
   output logic                    o_m0_rvalid,
   output logic [DATA_WIDTH-1:0]   o_m0_rdata,
   input  logic                    i_m1_req,
   input  logic                    i_m1_we,
   input  logic [ADDR_WIDTH-1:0]   i_m1_addr,
   input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_m1_wmask,
   output logic                    o_m1_ack,
   output logic                    o_m1_rvalid,
   output logic [DATA_WIDTH-1:0]   o_m1_rdata,
   output logic                    o_sdr_req,
   output logic                    o_sdr_we,
   output logic [ADDR_WIDTH-1:0]   o_sdr_addr,
   output logic [DATA_WIDTH-1:0]   o_sdr_wdata,
   output logic [DATA_WIDTH/8-1:0] o_sdr_wmask,
   input  logic                    i_sdr_ready,
   input  logic                    i_sdr_rvalid,
   input  logic [DATA_WIDTH-1:0]   i_sdr_rdata,
   output logic                    o_err
);
   localparam int MW = DATA_WIDTH / 8;
   localparam int PW = $clog2(MAX_RD);
   localparam int CW = $clog2(MAX_RD + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q;
   logic              owner_q;
   logic              rr_q;
   logic [SW-1:0]     starve_q;
   logic [MAX_RD-1:0] tag_q;
   logic [PW-1:0]     wptr_q;
   logic [PW-1:0]     rptr_q;
   logic [CW-1:0]     cnt_q;
   logic              sdr_req_q;
   logic              sdr_we_q;
   logic [ADDR_WIDTH-1:0] sdr_addr_q;
   logic [DATA_WIDTH-1:0] sdr_wdata_q;
   logic [MW-1:0]     sdr_wmask_q;
   logic [1:0]        rvalid_q;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;
   logic              err_q;

   logic              full;
   logic              empty;
   logic              elig0;
   logic              elig1;
   logic              win_valid;
   logic              win1;
   logic              accept;
   logic              push;
   logic              pop;
   logic              sdr_we_d;
   logic [ADDR_WIDTH-1:0] sdr_addr_d;
   logic [DATA_WIDTH-1:0] sdr_wdata_d;
   logic [MW-1:0]     sdr_wmask_d;

   always_comb begin
      full      = (cnt_q == CW'(MAX_RD));
      empty     = (cnt_q == '0);
      elig0     = i_m0_req & (i_m0_we | ~full);
      elig1     = i_m1_req & (i_m1_we | ~full);
      win_valid = elig0 | elig1;
      win1      = elig1;
      if (elig0 && elig1) begin
         if (PRIO_MODE == 0) win1 = rr_q;
         else                win1 = (starve_q == SW'(STARVE_LIMIT));
      end
      sdr_we_d    = win1 ? i_m1_we    : i_m0_we;
      sdr_addr_d  = win1 ? i_m1_addr  : i_m0_addr;
      sdr_wdata_d = win1 ? i_m1_wdata : i_m0_wdata;
      sdr_wmask_d = win1 ? i_m1_wmask : i_m0_wmask;
      accept = (state_q == GRANT) & i_sdr_ready;
      push   = accept & ~sdr_we_q;
      pop    = i_sdr_rvalid & ~empty;
   end

   // Ack is combinational so the master sees it in the accepting cycle.
   assign o_m0_ack    = accept & ~owner_q;
   assign o_m1_ack    = accept & owner_q;
   assign o_m0_rvalid = rvalid_q[0];
   assign o_m1_rvalid = rvalid_q[1];
   assign o_m0_rdata  = rdata0_q;
   assign o_m1_rdata  = rdata1_q;
   assign o_sdr_req   = sdr_req_q;
   assign o_sdr_we    = sdr_we_q;
   assign o_sdr_addr  = sdr_addr_q;
   assign o_sdr_wdata = sdr_wdata_q;
   assign o_sdr_wmask = sdr_wmask_q;
   assign o_err       = err_q;

   always_ff @(posedge i_sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         rr_q        <= 1'b0;
         starve_q    <= '0;
         tag_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
         sdr_req_q   <= 1'b0;
         sdr_we_q    <= 1'b0;
         sdr_addr_q  <= '0;
         sdr_wdata_q <= '0;
         sdr_wmask_q <= '0;
         rvalid_q    <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         rvalid_q <= '0;
         if (pop) begin
            rvalid_q[tag_q[rptr_q]] <= 1'b1;
            if (tag_q[rptr_q]) rdata1_q <= i_sdr_rdata;
            else               rdata0_q <= i_sdr_rdata;
            rptr_q <= rptr_q + PW'(1);
         end else if (i_sdr_rvalid) begin
            err_q <= 1'b1;
         end
         if (push) begin
            tag_q[wptr_q] <= owner_q;
            wptr_q        <= wptr_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  state_q     <= GRANT;
                  sdr_req_q   <= 1'b1;
                  owner_q     <= win1;
                  sdr_we_q    <= sdr_we_d;
                  sdr_addr_q  <= sdr_addr_d;
                  sdr_wdata_q <= sdr_wdata_d;
                  sdr_wmask_q <= sdr_wmask_d;
                  rr_q        <= ~win1;
                  if (win1)
                     starve_q <= '0;
                  else if (elig1 && starve_q != SW'(STARVE_LIMIT))
                     starve_q <= starve_q + SW'(1);
               end
            end
            GRANT: begin
               if (i_sdr_ready) begin
                  state_q   <= IDLE;
                  sdr_req_q <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a round-robin and a priority instance,
// each checked every cycle against a transaction-level reference model.
module tb_sdram_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 4;
   localparam int MAXRD = 4;
   localparam int LIM = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][1:0] req, we, ack, rv, cont;
   logic [1:0][1:0][AW-1:0] addr;
   logic [1:0][1:0][DW-1:0] wdata, rdata;
   logic [1:0][1:0][MW-1:0] wmask;
   logic [1:0] sreq, swe, sready, srv, err;
   logic [1:0][AW-1:0] saddr;
   logic [1:0][DW-1:0] swdata, srdata;
   logic [1:0][MW-1:0] swmask;

   for (genvar g = 0; g < 2; g++) begin : gd
      sdram_port_arbiter #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RD(MAXRD),
         .PRIO_MODE(g), .STARVE_LIMIT(LIM)
      ) u_dut (
         .i_sysclk(clk), .i_rst_n(rst_n),
         .i_m0_req(req[g][0]), .i_m0_we(we[g][0]),
         .i_m0_addr(addr[g][0]), .i_m0_wdata(wdata[g][0]),
         .i_m0_wmask(wmask[g][0]), .o_m0_ack(ack[g][0]),
         .o_m0_rvalid(rv[g][0]), .o_m0_rdata(rdata[g][0]),
         .i_m1_req(req[g][1]), .i_m1_we(we[g][1]),
         .i_m1_addr(addr[g][1]), .i_m1_wdata(wdata[g][1]),
         .i_m1_wmask(wmask[g][1]), .o_m1_ack(ack[g][1]),
         .o_m1_rvalid(rv[g][1]), .o_m1_rdata(rdata[g][1]),
         .o_sdr_req(sreq[g]), .o_sdr_we(swe[g]),
         .o_sdr_addr(saddr[g]), .o_sdr_wdata(swdata[g]),
         .o_sdr_wmask(swmask[g]), .i_sdr_ready(sready[g]),
         .i_sdr_rvalid(srv[g]), .i_sdr_rdata(srdata[g]),
         .o_err(err[g])
      );
   end

   int checks = 0;
   int errors = 0;
   bit rnd_on = 0;
   bit rnd_new = 0;

   // Reference model: one command slot per instance plus a queue of owners.
   bit busy[2];
   int own[2];
   int rr[2];
   int starve[2];
   int tags[2][$];
   int glog[2][$];
   logic we_e[2];
   logic [AW-1:0] addr_e[2];
   logic [DW-1:0] wdata_e[2];
   logic [MW-1:0] wmask_e[2];
   logic err_e[2];
   logic [1:0] rv_e[2];
   logic [DW-1:0] rd_e[2][2];
   logic [1:0] obs_ack[2];
   logic [1:0] obs_rv[2];
   logic [DW-1:0] obs_rd[2][2];
   logic obs_err[2];
   logic [1:0] seen[2];

   function automatic void cmp(string tag, logic [63:0] o, logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endfunction

   function automatic void model_reset(int p);
      busy[p] = 0; own[p] = 0; rr[p] = 0; starve[p] = 0;
      tags[p].delete(); glog[p].delete();
      err_e[p] = 0; rv_e[p] = '0; rd_e[p][0] = '0; rd_e[p][1] = '0;
      seen[p] = '0;
   endfunction

   function automatic void check_outputs(int p);
      string s = $sformatf("p%0d_", p);
      logic ea;
      cmp({s, "sdr_req"}, sreq[p], busy[p]);
      if (busy[p]) begin
         cmp({s, "sdr_we"}, swe[p], we_e[p]);
         cmp({s, "sdr_addr"}, saddr[p], addr_e[p]);
         cmp({s, "sdr_wdata"}, swdata[p], wdata_e[p]);
         cmp({s, "sdr_wmask"}, swmask[p], wmask_e[p]);
      end
      for (int m = 0; m < 2; m++) begin
         ea = busy[p] && sready[p] && (own[p] == m);
         cmp($sformatf("%sack%0d", s, m), ack[p][m], ea);
         cmp($sformatf("%srvalid%0d", s, m), rv[p][m], rv_e[p][m]);
         cmp($sformatf("%srdata%0d", s, m), rdata[p][m], rd_e[p][m]);
         obs_ack[p][m] = ack[p][m];
         obs_rv[p][m] = rv[p][m];
         obs_rd[p][m] = rdata[p][m];
         if (ack[p][m]) begin
            seen[p][m] = 1'b1;
            glog[p].push_back(m);
         end
      end
      cmp({s, "err"}, err[p], err_e[p]);
      obs_err[p] = err[p];
   endfunction

   function automatic void model_step(int p);
      bit full = tags[p].size() >= MAXRD;
      bit e0, e1;
      int w, t;
      rv_e[p] = '0;
      if (srv[p]) begin
         if (tags[p].size() > 0) begin
            t = tags[p].pop_front();
            rv_e[p][t] = 1'b1;
            rd_e[p][t] = srdata[p];
         end else err_e[p] = 1'b1;
      end
      if (busy[p]) begin
         if (sready[p]) begin
            if (!we_e[p]) tags[p].push_back(own[p]);
            busy[p] = 0;
         end
      end else begin
         e0 = req[p][0] && (we[p][0] || !full);
         e1 = req[p][1] && (we[p][1] || !full);
         w = -1;
         if (e0 && e1) begin
            if (p == 0) w = rr[p];
            else w = (starve[p] == LIM) ? 1 : 0;
         end else if (e0) w = 0;
         else if (e1) w = 1;
         if (w >= 0) begin
            busy[p] = 1; own[p] = w;
            we_e[p] = we[p][w]; addr_e[p] = addr[p][w];
            wdata_e[p] = wdata[p][w]; wmask_e[p] = wmask[p][w];
            rr[p] = 1 - w;
            if (w == 1) starve[p] = 0;
            else if (e1) starve[p] = (starve[p] < LIM) ? starve[p] + 1 : LIM;
         end
      end
   endfunction

   task automatic issue(int p, int m, logic w, logic [AW-1:0] a,
                        logic [DW-1:0] d, logic [MW-1:0] k);
      req[p][m] = 1'b1; we[p][m] = w; addr[p][m] = a;
      wdata[p][m] = d; wmask[p][m] = k; seen[p][m] = 1'b0;
   endtask

   task automatic clear_inputs();
      req = '0; we = '0; addr = '0; wdata = '0; wmask = '0; cont = '0;
      sready = '0; srv = '0; srdata = '0;
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int p = 0; p < 2; p++) check_outputs(p);
      for (int p = 0; p < 2; p++) model_step(p);
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         for (int m = 0; m < 2; m++) begin
            if (obs_ack[p][m]) begin
               if (cont[p][m]) addr[p][m] += 4;
               else req[p][m] = 1'b0;
            end
            if (rnd_new && !req[p][m] && $urandom_range(0, 2) == 0)
               issue(p, m, 1'($urandom), $urandom, $urandom, 4'($urandom));
         end
         if (rnd_on) begin
            sready[p] = ($urandom_range(0, 3) != 0);
            srv[p] = (tags[p].size() > 0) && ($urandom_range(0, 2) == 0);
            srdata[p] = $urandom;
         end else srv[p] = 1'b0;
      end
   endtask

   task automatic wait_ack(int m, string tag, int budget);
      int n = 0;
      while (!(seen[0][m] && seen[1][m]) && n < budget) begin
         cycle();
         n++;
      end
      cmp(tag, {seen[0][m], seen[1][m]}, 2'b11);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rnd_on = 0; rnd_new = 0;
      clear_inputs();
      for (int p = 0; p < 2; p++) model_reset(p);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      for (int p = 0; p < 2; p++) model_reset(p);
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
         check_outputs(p);
         cmp($sformatf("p%0d_rst_we", p), swe[p], 1'b0);
         cmp($sformatf("p%0d_rst_addr", p), saddr[p], 0);
         cmp($sformatf("p%0d_rst_wdata", p), swdata[p], 0);
         cmp($sformatf("p%0d_rst_wmask", p), swmask[p], 0);
      end

      // Single read with a delayed return.
      do_reset();
      sready = 2'b11;
      for (int p = 0; p < 2; p++) issue(p, 0, 1'b0, 32'h100, 0, 4'hF);
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) cmp("t1_ack_cycle1", obs_ack[p][0], 1'b1);
      cycle();
      cycle();
      srv = 2'b11; srdata = '{32'hDEADBEEF, 32'hDEADBEEF};
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) begin
         cmp("t1_rvalid0", obs_rv[p][0], 1'b1);
         cmp("t1_rvalid1", obs_rv[p][1], 1'b0);
         cmp("t1_rdata0", obs_rd[p][0], 32'hDEADBEEF);
      end

      // Both masters writing back to back: alternation vs starvation guard.
      do_reset();
      sready = 2'b11;
      cont = '1;
      for (int p = 0; p < 2; p++) begin
         issue(p, 0, 1'b1, 32'h1000, 32'h11, 4'h3);
         issue(p, 1, 1'b1, 32'h2000, 32'h22, 4'hC);
      end
      for (int n = 0; n < 60 && glog[1].size() < 18; n++) cycle();
      cmp("t2_grant_count", (glog[0].size() >= 18 && glog[1].size() >= 18), 1'b1);
      for (int i = 0; i < 18 && i < glog[0].size() && i < glog[1].size(); i++) begin
         cmp($sformatf("t2_rr_grant%0d", i), glog[0][i], i % 2);
         cmp($sformatf("t3_prio_grant%0d", i), glog[1][i], (i % 9 == 8) ? 1 : 0);
      end
      cont = '0;
      req = '0;
      repeat (3) cycle();

      // Fill the tag queue, then a fifth read waits behind a write.
      do_reset();
      sready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 2; p++)
            issue(p, k % 2, 1'b0, AW'(32'h300 + k * 4), 0, 4'hF);
         wait_ack(k % 2, $sformatf("t4_read%0d", k), 10);
      end
      for (int p = 0; p < 2; p++) begin
         issue(p, 0, 1'b0, 32'h310, 0, 4'hF);
         issue(p, 1, 1'b1, 32'h700, 32'h77, 4'h5);
      end
      wait_ack(1, "t4_m1_write", 10);
      repeat (4) cycle();
      for (int p = 0; p < 2; p++) cmp("t4_fifth_blocked", seen[p][0], 1'b0);
      for (int k = 0; k < 4; k++) begin
         srv = 2'b11;
         srdata = '{DW'(32'hA000_0000 + k), DW'(32'hA000_0000 + k)};
         cycle();
         cycle();
         for (int p = 0; p < 2; p++) begin
            cmp($sformatf("t4_route%0d", k), obs_rv[p][k % 2], 1'b1);
            cmp($sformatf("t4_word%0d", k), obs_rd[p][k % 2], 32'hA000_0000 + k);
         end
      end
      wait_ack(0, "t4_fifth_granted", 20);
      srv = 2'b11; srdata = '{32'hB0, 32'hB0};
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) cmp("t4_fifth_data", obs_rd[p][0], 32'hB0);

      // Return with nothing outstanding.
      do_reset();
      sready = 2'b11;
      srv = 2'b11; srdata = '{32'h1234, 32'h1234};
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) begin
         cmp("t5_err_set", obs_err[p], 1'b1);
         cmp("t5_no_rv", obs_rv[p], 2'b00);
      end
      for (int p = 0; p < 2; p++) issue(p, 1, 1'b0, 32'h400, 0, 4'hF);
      wait_ack(1, "t5_read", 10);
      srv = 2'b11; srdata = '{32'h5678, 32'h5678};
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) begin
         cmp("t5_rv_after", obs_rv[p][1], 1'b1);
         cmp("t5_err_sticky", obs_err[p], 1'b1);
      end

      // Asynchronous reset while a command waits in GRANT.
      do_reset();
      for (int p = 0; p < 2; p++) issue(p, 0, 1'b1, 32'h500, 32'h55, 4'hF);
      cycle();
      cycle();
      for (int p = 0; p < 2; p++) cmp("t6_pre_req", sreq[p], 1'b1);
      sready = 2'b11;
      rst_n = 1'b0;
      #1;
      for (int p = 0; p < 2; p++) begin
         cmp("t6_req_cleared", sreq[p], 1'b0);
         cmp("t6_no_ack", ack[p], 2'b00);
         cmp("t6_addr_cleared", saddr[p], 0);
      end
      clear_inputs();
      for (int p = 0; p < 2; p++) model_reset(p);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sready = 2'b11;
      for (int p = 0; p < 2; p++) issue(p, 1, 1'b1, 32'h600, 32'h66, 4'h9);
      wait_ack(1, "t6_fresh_m1", 10);

      // Random traffic against the model.
      do_reset();
      rnd_on = 1;
      rnd_new = 1;
      repeat (800) cycle();
      rnd_new = 0;
      repeat (100) cycle();
      rnd_on = 0;
      repeat (4) cycle();
      for (int p = 0; p < 2; p++) cmp("t7_idle_at_end", req[p], 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
